// File: rtl/smg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display path.
package smg_pkg;

    localparam int         NUM_DIGITS = 3;
    localparam logic [3:0] NIB_BLANK  = 4'hF;
    localparam logic [3:0] NIB_DASH   = 4'hA;

    // Active-low digit select, indexed by digit position (0 = rightmost).
    localparam logic [NUM_DIGITS-1:0][2:0] SCAN_PAT = {3'b011, 3'b101, 3'b110};

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WAIT_FRAME
    } state_t;

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

endpackage

// File: rtl/smg_bin2bcd_seq.sv
// Sequential 12-bit binary to 3-digit BCD converter (shift-and-add-3, 12 cycles).
// Out-of-range inputs (> 999) report overflow and present dashes on all digits.
module smg_bin2bcd_seq
    import smg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] bin,
    output logic        done,
    output digits_t     bcd,
    output logic        overflow
);

    logic [11:0] bin_reg;
    logic [11:0] bcd_reg;
    logic [3:0]  count_reg;
    logic        busy_reg;
    logic        overflow_reg;
    logic [11:0] bcd_adj;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_reg      <= '0;
            bcd_reg      <= '0;
            count_reg    <= '0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (start) begin
            bin_reg      <= bin;
            bcd_reg      <= '0;
            count_reg    <= '0;
            busy_reg     <= 1'b1;
            overflow_reg <= (bin > 12'd999);
        end else if (busy_reg) begin
            {bcd_reg, bin_reg} <= {bcd_adj[10:0], bin_reg, 1'b0};
            count_reg          <= count_reg + 4'd1;
            if (count_reg == 4'd11) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // Done marks the cycle of the final shift; the result registers settle at its edge.
    assign done     = busy_reg && (count_reg == 4'd11);
    assign overflow = overflow_reg;
    assign bcd      = overflow_reg ? {NUM_DIGITS{NIB_DASH}} : digits_t'(bcd_reg);

endmodule

// File: rtl/smg_display_scheduler.sv
// Accepts values over valid/ready, converts them to BCD and commits them to the
// display buffer only at a frame boundary, while running the free digit scan.
module smg_display_scheduler
    import smg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [11:0] Number_Sig,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    output logic        Update_Done,
    output logic        Overflow,
    output logic [3:0]  Number_Data,
    output logic [2:0]  Scan_Sig
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic [1:0]       index_reg;
    logic [1:0]       index_next;
    logic             tick;
    logic             fb;
    digits_t          buffer_reg;
    logic             overflow_reg;
    logic [2:0]       scan_reg;
    logic [2:0]       scan_next;
    logic [3:0]       nibble_reg;
    logic [3:0]       nibble_next;
    logic [NUM_DIGITS-1:0] blank;
    state_t           state_reg;
    state_t           state_next;
    logic             conv_start;
    logic             conv_done;
    digits_t          conv_bcd;
    logic             conv_ovf;
    logic             commit;

    smg_bin2bcd_seq u_bin2bcd (
        .clk      (CLK),
        .rst_n    (RSTn),
        .start    (conv_start),
        .bin      (Number_Sig),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    assign tick       = (div_reg == DIV_W'(SCAN_DIV - 1));
    assign fb         = tick && (index_reg == 2'd2);
    assign index_next = !tick ? index_reg : ((index_reg == 2'd2) ? 2'd0 : index_reg + 2'd1);

    // Leading zeros blank from the left; dashes are nonzero so they always show.
    assign blank[0] = 1'b0;
    assign blank[2] = BLANK_LZ && (buffer_reg[2] == 4'd0);
    assign blank[1] = blank[2] && (buffer_reg[1] == 4'd0);

    always_comb begin
        scan_next   = SCAN_PAT[0];
        nibble_next = blank[0] ? NIB_BLANK : buffer_reg[0];
        case (index_next)
            2'd1: begin
                scan_next   = SCAN_PAT[1];
                nibble_next = blank[1] ? NIB_BLANK : buffer_reg[1];
            end
            2'd2: begin
                scan_next   = SCAN_PAT[2];
                nibble_next = blank[2] ? NIB_BLANK : buffer_reg[2];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Req_Valid) begin
                    conv_start = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (fb) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_reg    <= IDLE;
            div_reg      <= '0;
            index_reg    <= 2'd0;
            scan_reg     <= SCAN_PAT[0];
            nibble_reg   <= NIB_BLANK;
            buffer_reg   <= {NUM_DIGITS{NIB_BLANK}};
            overflow_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= tick ? '0 : div_reg + DIV_W'(1);
            index_reg  <= index_next;
            scan_reg   <= scan_next;
            nibble_reg <= nibble_next;
            if (commit) begin
                buffer_reg   <= conv_bcd;
                overflow_reg <= conv_ovf;
            end
        end
    end

    assign Req_Ready   = (state_reg == IDLE);
    assign Update_Done = commit;
    assign Overflow    = overflow_reg;
    assign Number_Data = nibble_reg;
    assign Scan_Sig    = scan_reg;

endmodule

// File: tb/tb_smg_display_scheduler.sv
// Bench for smg_display_scheduler: table vectors, random values against a decimal
// reference model, and hand sequences for held requests and reset mid-conversion.
module tb_smg_display_scheduler;

    localparam int SD    = 4;
    localparam int FRAME = 3 * SD;

    logic        CLK;
    logic        RSTn;
    logic [11:0] Number_Sig;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Update_Done;
    logic        Overflow;
    logic [3:0]  Number_Data;
    logic [2:0]  Scan_Sig;

    int checks = 0;
    int passed = 0;
    int cyc;
    logic [2:0] pat [3];

    typedef struct {
        logic [11:0] v;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic        ovf;
    } vec_t;
    vec_t vecs [7];

    smg_display_scheduler #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Number_Sig  (Number_Sig),
        .Req_Valid   (Req_Valid),
        .Req_Ready   (Req_Ready),
        .Update_Done (Update_Done),
        .Overflow    (Overflow),
        .Number_Data (Number_Data),
        .Scan_Sig    (Scan_Sig)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycles since reset release; the scan position and frame boundaries follow from it.
    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected {digit2, digit1, digit0} from decimal arithmetic.
    function automatic logic [11:0] ref_disp(input int v);
        int d0, d1, d2;
        logic [11:0] r;
        if (v > 999) return {4'hA, 4'hA, 4'hA};
        d0 = v % 10;
        d1 = (v / 10) % 10;
        d2 = v / 100;
        if (d2 == 0) begin
            d2 = 15;
            if (d1 == 0) d1 = 15;
        end
        r = {d2[3:0], d1[3:0], d0[3:0]};
        return r;
    endfunction

    task automatic check_display(input logic [11:0] exp, input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            idx = (cyc / SD) % 3;
            check("scan_sig", Scan_Sig, pat[idx]);
            check($sformatf("digit%0d", idx), Number_Data, exp[idx*4 +: 4]);
        end
    endtask

    task automatic send(input logic [11:0] v, output int k0);
        int n;
        n = 0;
        while (!Req_Ready && n < 64) begin
            @(negedge CLK);
            n++;
        end
        check("ready_idle", Req_Ready, 1);
        Req_Valid  = 1'b1;
        Number_Sig = v;
        k0         = cyc;
        @(negedge CLK);
        Req_Valid  = 1'b0;
        Number_Sig = 12'($urandom);
        check("ready_fall", Req_Ready, 0);
    endtask

    // Commit lands on the first frame boundary at least 13 cycles after acceptance.
    task automatic wait_pulse(input int k0);
        int kc;
        int n;
        kc = k0 + 13;
        while (kc % FRAME != FRAME - 1) kc++;
        n = 0;
        while (!Update_Done && n < 4 * FRAME) begin
            @(negedge CLK);
            Number_Sig = 12'($urandom);
            n++;
        end
        check("commit_cycle", cyc, kc);
    endtask

    task automatic finish_commit(input logic [11:0] exp, input logic eovf);
        @(negedge CLK);
        check("done_pulse_width", Update_Done, 0);
        check("ready_after_done", Req_Ready, 1);
        check("overflow", Overflow, eovf);
        check_display(exp, FRAME - 1);
    endtask

    initial begin
        int k0;
        int k1;
        int seen;
        logic [11:0] v;

        pat[0] = 3'b110; pat[1] = 3'b101; pat[2] = 3'b011;
        vecs[0] = '{12'd123,  4'd3, 4'd2, 4'd1, 1'b0};
        vecs[1] = '{12'd7,    4'd7, 4'hF, 4'hF, 1'b0};
        vecs[2] = '{12'd0,    4'd0, 4'hF, 4'hF, 1'b0};
        vecs[3] = '{12'd405,  4'd5, 4'd0, 4'd4, 1'b0};
        vecs[4] = '{12'd1000, 4'hA, 4'hA, 4'hA, 1'b1};
        vecs[5] = '{12'd4095, 4'hA, 4'hA, 4'hA, 1'b1};
        vecs[6] = '{12'd999,  4'd9, 4'd9, 4'd9, 1'b0};

        RSTn       = 1'b0;
        Req_Valid  = 1'b0;
        Number_Sig = '0;
        repeat (3) @(negedge CLK);
        check("rst_scan", Scan_Sig, 3'b110);
        check("rst_data", Number_Data, 4'hF);
        check("rst_ready", Req_Ready, 1);
        check("rst_done", Update_Done, 0);
        check("rst_ovf", Overflow, 0);
        RSTn = 1'b1;
        check_display(12'hFFF, 16);
        $display("reset: scan order and blank buffer checked");

        foreach (vecs[i]) begin
            send(vecs[i].v, k0);
            wait_pulse(k0);
            finish_commit({vecs[i].d2, vecs[i].d1, vecs[i].d0}, vecs[i].ovf);
            $display("vector %0d: value=%0d expect %h%h%h ovf=%0d", i, vecs[i].v,
                     vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].ovf);
        end

        for (int i = 0; i < 16; i++) begin
            v = (i % 3 == 0) ? 12'($urandom_range(0, 99)) : 12'($urandom_range(0, 4095));
            send(v, k0);
            wait_pulse(k0);
            finish_commit(ref_disp(int'(v)), v > 12'd999);
            $display("random %0d: value=%0d expect %h", i, v, ref_disp(int'(v)));
        end

        // Held request with a wandering value: only the first value is used.
        send(12'd321, k0);
        Req_Valid = 1'b1;
        wait_pulse(k0);
        Number_Sig = 12'd456;
        @(negedge CLK);
        check("hold_ready_after_done", Req_Ready, 1);
        k1 = cyc;
        @(negedge CLK);
        Req_Valid = 1'b0;
        check("hold_second_accepted", Req_Ready, 0);
        check("hold_overflow", Overflow, 0);
        check_display(ref_disp(321), FRAME - 2);
        wait_pulse(k1);
        finish_commit(ref_disp(456), 1'b0);
        $display("held request: 321 then 456");

        // Reset during conversion after a committed value.
        send(12'd123, k0);
        wait_pulse(k0);
        finish_commit(ref_disp(123), 1'b0);
        send(12'd500, k0);
        repeat (4) @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check("midrst_data", Number_Data, 4'hF);
        check("midrst_scan", Scan_Sig, 3'b110);
        check("midrst_ready", Req_Ready, 1);
        check("midrst_done", Update_Done, 0);
        @(negedge CLK);
        RSTn = 1'b1;
        seen = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge CLK);
            if (Update_Done) seen++;
        end
        check("midrst_no_commit", seen, 0);
        check("midrst_ready_after", Req_Ready, 1);
        check_display(12'hFFF, FRAME);
        $display("reset mid-conversion: buffer blank, no commit");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/smg_display_scheduler.md
Name: smg_display_scheduler

Overview:
Sequencing controller for the 3-digit multiplexed 7-segment display path. It accepts 12-bit binary values from upstream logic over a valid/ready handshake and converts each one to BCD sequentially. It commits the result to the display buffer only at a frame boundary, so the display never tears. It also runs the digit scan, driving the per-digit nibble into smg_encode_module and the active-low digit select to the pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (1 ms at 50 MHz); legal range >= 2
BLANK_LZ, 1, 1 = blank leading zeros (digit 0, the rightmost, is never blanked)

Ports:
CLK  input  1  system clock
RSTn  input  1  asynchronous active-low reset
Number_Sig  input  12  binary value to display
Req_Valid  input  1  Number_Sig valid
Req_Ready  output  1  scheduler can accept a new value
Update_Done  output  1  one-cycle pulse when a new value is committed to the display buffer
Overflow  output  1  committed value was > 999
Number_Data  output  4  nibble for the current digit, to smg_encode_module
Scan_Sig  output  3  active-low one-hot digit select

Behaviour:
- Clock and reset: one clock CLK; reset RSTn is asynchronous and active-low.
- Reset values:
  - Scan_Sig = 3'b110, digit index = 0, divider = 0.
  - Display buffer = all NIB_BLANK (4'hF); Number_Data = 4'hF.
  - Req_Ready = 1, Update_Done = 0, Overflow = 0, FSM = IDLE.
- Reset mid-conversion discards the pending value; nothing is committed.
- Scan engine (free-running):
  - Divider counts 0..SCAN_DIV-1; tick = (divider == SCAN_DIV-1).
  - On tick, index advances 0 -> 1 -> 2 -> 0.
  - Scan_Sig is registered: index 0 -> 3'b110, 1 -> 3'b101, 2 -> 3'b011.
  - Number_Data is registered and updates in the same cycle as Scan_Sig: Number_Data = buffer[index], or NIB_BLANK if blanked.
  - Frame boundary (fb) = tick while index == 2, i.e. every 3*SCAN_DIV cycles.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit 2 is blanked if it is 0.
  - Digit 1 is blanked if digits 2 and 1 are both 0.
  - Digit 0 is always shown.
  - Dashes are never blanked.
- FSM:
  - IDLE: Req_Ready = 1. If Req_Valid = 1, capture Number_Sig, set Req_Ready = 0 next cycle, go to CONVERT.
  - CONVERT: sequential double-dabble, 12 shift cycles (add-3 on every BCD nibble >= 5 before each shift), then go to WAIT_FRAME. If the captured value > 999, the pending result is {DASH, DASH, DASH} and the overflow flag is pending. CONVERT takes 12 cycles regardless.
  - WAIT_FRAME: on fb, load the buffer from pending, update Overflow, pulse Update_Done for 1 cycle, go to IDLE. Req_Ready returns to 1 the cycle after the pulse.
  - Conversion finishing in the same cycle as fb does not commit; it waits for the next fb.
- Handshake:
  - Transfer occurs when Req_Valid && Req_Ready.
  - Req_Valid while not ready is ignored; no queueing, the source holds.
  - Number_Sig changes after acceptance have no effect.
- Latency: accept -> commit is 13 to 13+3*SCAN_DIV cycles.
- The new buffer is first visible on the Number_Data update that follows commit, which is digit 0.
- Buffer and Overflow hold between updates; Overflow is cleared by the next in-range commit.

Decomposition:
- Package smg_pkg holds:
  - NUM_DIGITS = 3
  - NIB_BLANK = 4'hF
  - NIB_DASH = 4'hA
  - SCAN_PAT array {3'b110, 3'b101, 3'b011}
  - FSM state typedef {IDLE, CONVERT, WAIT_FRAME}
- smg_encode_module decodes NIB_BLANK to all segments off and NIB_DASH to segment g only.
- One sub-module: smg_bin2bcd_seq (start, 12-bit bin in, done, 3x4-bit BCD out, overflow out). The FSM and scan engine stay in the top.

Test Plan (SCAN_DIV = 4):
1. Reset -> Scan_Sig = 3'b110, Number_Data = 4'hF, Req_Ready = 1; scan order 110, 101, 011, 110 at 4-cycle spacing.
2. Send 12'd123 -> Req_Ready falls the next cycle; Update_Done pulses on the first fb >= 13 cycles later; the next frame shows digit0 = 3, digit1 = 2, digit2 = 1; Overflow = 0.
3. Send 12'd7 with BLANK_LZ = 1 -> digits show 7, F, F. Send 12'd0 -> 0, F, F. Send 12'd405 -> 5, 0, 4 (embedded zero not blanked).
4. Send 12'd1000, then 12'd4095 -> each gives A, A, A with Overflow = 1. Then send 12'd999 -> 9, 9, 9 with Overflow = 0.
5. Hold Req_Valid with a changing Number_Sig during CONVERT/WAIT_FRAME -> no accept; the display matches the first value only. The second value is accepted one cycle after Update_Done.
6. Assert RSTn = 0 mid-CONVERT after a prior 123 commit -> buffer returns to F, F, F; no Update_Done; Req_Ready = 1 after reset release.
